// File: rtl/iob_cache_req_queue.sv
// iob_cache_req_queue
//   Request queue in front of the cache IOb-bus front-end. Client requests
//   are buffered in a request FIFO and presented in order on the IOb bus.
//   Read data returns in order through a response FIFO. A read is issued only
//   if a response slot is guaranteed for it. The cache cannot stall rvalid,
//   so no returned read can ever be dropped.
//
// Ports
//   clk_i, arst_i, cke_i        clock, async active-high reset, clock enable
//   req_valid_i / req_ready_o   client request handshake
//   req_addr_i, req_wdata_i,
//   req_wstrb_i, req_acache_i   request payload (wstrb == 0 means read)
//   iob_avalid_o / iob_ready_i  request handshake toward the cache
//   iob_addr_o .. iob_acache_o  request FIFO head entry
//   iob_rvalid_i, iob_rdata_i   cache read data, one cycle per read
//   rsp_valid_o / rsp_ready_i   client response handshake
//   rsp_rdata_o                 response FIFO head data
//   idle_o                      both FIFOs empty and no reads outstanding
//   err_o                       sticky: stray rvalid seen
module iob_cache_req_queue #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int FIFO_W = 2
) (
    input  logic                clk_i,
    input  logic                arst_i,
    input  logic                cke_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [DATA_W-1:0]   req_wdata_i,
    input  logic [DATA_W/8-1:0] req_wstrb_i,
    input  logic [3:0]          req_acache_i,
    output logic                iob_avalid_o,
    output logic [ADDR_W-1:0]   iob_addr_o,
    output logic [DATA_W-1:0]   iob_wdata_o,
    output logic [DATA_W/8-1:0] iob_wstrb_o,
    output logic [3:0]          iob_acache_o,
    input  logic                iob_ready_i,
    input  logic                iob_rvalid_i,
    input  logic [DATA_W-1:0]   iob_rdata_i,
    output logic                rsp_valid_o,
    output logic [DATA_W-1:0]   rsp_rdata_o,
    input  logic                rsp_ready_i,
    output logic                idle_o,
    output logic                err_o
);

    localparam int D      = 1 << FIFO_W;
    localparam int STRB_W = DATA_W / 8;
    localparam logic [FIFO_W:0] DEPTH = {1'b1, {FIFO_W{1'b0}}};

    // Request FIFO storage and control
    logic [ADDR_W-1:0] req_addr_mem   [D];
    logic [DATA_W-1:0] req_wdata_mem  [D];
    logic [STRB_W-1:0] req_wstrb_mem  [D];
    logic [3:0]        req_acache_mem [D];
    logic [FIFO_W-1:0] req_wr_ptr, req_rd_ptr;
    logic [FIFO_W:0]   req_level;

    // Response FIFO storage and control
    logic [DATA_W-1:0] rsp_mem [D];
    logic [FIFO_W-1:0] rsp_wr_ptr, rsp_rd_ptr;
    logic [FIFO_W:0]   rsp_level;

    logic [FIFO_W:0]   rd_out;
    logic              err_q;

    logic              req_empty, rsp_empty, rsp_full;
    logic              head_is_write, credit_ok;
    logic [FIFO_W+1:0] credit_sum;
    logic              req_push, req_pop, rsp_push, rsp_pop, stray;
    logic              rd_inc;

    assign req_empty = (req_level == '0);
    assign rsp_empty = (rsp_level == '0);
    assign rsp_full  = (rsp_level == DEPTH);

    assign head_is_write = |req_wstrb_mem[req_rd_ptr];

    // Every issued-but-unreturned read owns a response slot, so the sum of
    // outstanding reads and stored responses never exceeds the FIFO depth.
    assign credit_sum = {1'b0, rd_out} + {1'b0, rsp_level};
    assign credit_ok  = (credit_sum < {1'b0, DEPTH});

    assign req_ready_o  = (req_level != DEPTH);
    assign iob_avalid_o = !req_empty && (head_is_write || credit_ok);
    assign iob_addr_o   = req_addr_mem[req_rd_ptr];
    assign iob_wdata_o  = req_wdata_mem[req_rd_ptr];
    assign iob_wstrb_o  = req_wstrb_mem[req_rd_ptr];
    assign iob_acache_o = req_acache_mem[req_rd_ptr];

    assign rsp_valid_o = !rsp_empty;
    assign rsp_rdata_o = rsp_mem[rsp_rd_ptr];

    assign idle_o = req_empty && rsp_empty && (rd_out == '0);
    assign err_o  = err_q;

    assign req_push = cke_i && req_valid_i && req_ready_o;
    assign req_pop  = cke_i && iob_avalid_o && iob_ready_i;
    assign rsp_pop  = cke_i && rsp_valid_o && rsp_ready_i;
    // A pop in the same cycle frees a slot, so a full response FIFO still
    // accepts read data when the client drains it at the same edge.
    assign stray    = cke_i && iob_rvalid_i &&
                      ((rd_out == '0) || (rsp_full && !rsp_pop));
    assign rsp_push = cke_i && iob_rvalid_i && !stray;
    assign rd_inc   = req_pop && !head_is_write;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < D; i++) begin
                req_addr_mem[i]   <= '0;
                req_wdata_mem[i]  <= '0;
                req_wstrb_mem[i]  <= '0;
                req_acache_mem[i] <= '0;
                rsp_mem[i]        <= '0;
            end
        end else begin
            if (req_push) begin
                req_addr_mem[req_wr_ptr]   <= req_addr_i;
                req_wdata_mem[req_wr_ptr]  <= req_wdata_i;
                req_wstrb_mem[req_wr_ptr]  <= req_wstrb_i;
                req_acache_mem[req_wr_ptr] <= req_acache_i;
            end
            if (rsp_push) begin
                rsp_mem[rsp_wr_ptr] <= iob_rdata_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            req_wr_ptr <= '0;
            req_rd_ptr <= '0;
            req_level  <= '0;
            rsp_wr_ptr <= '0;
            rsp_rd_ptr <= '0;
            rsp_level  <= '0;
            rd_out     <= '0;
            err_q      <= 1'b0;
        end else begin
            if (req_push) req_wr_ptr <= req_wr_ptr + 1'b1;
            if (req_pop)  req_rd_ptr <= req_rd_ptr + 1'b1;
            case ({req_push, req_pop})
                2'b10:   req_level <= req_level + 1'b1;
                2'b01:   req_level <= req_level - 1'b1;
                default: req_level <= req_level;
            endcase

            if (rsp_push) rsp_wr_ptr <= rsp_wr_ptr + 1'b1;
            if (rsp_pop)  rsp_rd_ptr <= rsp_rd_ptr + 1'b1;
            case ({rsp_push, rsp_pop})
                2'b10:   rsp_level <= rsp_level + 1'b1;
                2'b01:   rsp_level <= rsp_level - 1'b1;
                default: rsp_level <= rsp_level;
            endcase

            // A stray rvalid never reaches rsp_push, so it leaves rd_out alone.
            case ({rd_inc, rsp_push})
                2'b10:   rd_out <= rd_out + 1'b1;
                2'b01:   rd_out <= rd_out - 1'b1;
                default: rd_out <= rd_out;
            endcase

            if (stray) err_q <= 1'b1;
        end
    end

endmodule
